// File: rtl/regfile_pkg.sv
// Shared constants and types for the regfile_sb register file and scoreboard.
package regfile_pkg;

    localparam int RF_XLEN = 32;
    localparam int RF_NREG = 32;
    localparam int RF_NRD  = 2;
    localparam int RF_NWR  = 2;
    localparam int RF_AW   = $clog2(RF_NREG);

    typedef logic [RF_AW-1:0]   reg_addr_t;
    typedef logic [RF_XLEN-1:0] reg_data_t;

    // Width of a write-port index; a single port still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of regfile_sb: read ports, write ports, issue strobe, busy count.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int NRD  = RF_NRD,
    parameter int NWR  = RF_NWR
) ();

    localparam int AW = $clog2(NREG);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic [NWR-1:0]           wr_clr;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic [AW:0]              busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_wr_arb.sv
// Folds the write ports into a per-register write enable and winning-port select.
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int NREG = RF_NREG,
    parameter int NWR  = RF_NWR,
    parameter int AW   = $clog2(NREG),
    parameter int SW   = sel_width(NWR)
) (
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR-1:0][AW-1:0]  wr_addr,
    output logic [NREG-1:0]         reg_we,
    output logic [NREG-1:0][SW-1:0] reg_sel
);

    logic hit_s;

    // Ascending port scan so the highest-index port to a register overwrites the select.
    always_comb begin
        reg_we  = '0;
        reg_sel = '0;
        hit_s   = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            for (int p = 0; p < NWR; p++) begin
                hit_s      = wr_en[p] && (wr_addr[p] == AW'(r));
                reg_we[r]  = reg_we[r] | hit_s;
                reg_sel[r] = hit_s ? SW'(p) : reg_sel[r];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy scoreboard; x0 reads zero, never busy.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = RF_XLEN,
    parameter int NREG = RF_NREG,
    parameter int NRD  = RF_NRD,
    parameter int NWR  = RF_NWR
) (
    input  logic         clk,
    input  logic         n_rst,
    regfile_sb_if.slave  bus
);

    localparam int AW = $clog2(NREG);
    localparam int SW = sel_width(NWR);

    logic [NREG-1:0][XLEN-1:0] rf_r;
    logic [NREG-1:0]           busy_r;
    logic [AW:0]               busy_cnt_r;

    logic [NREG-1:0]           reg_we_s;
    logic [NREG-1:0][SW-1:0]   reg_sel_s;
    logic [NREG-1:0]           busy_nxt_s;
    logic [AW:0]               cnt_nxt_s;
    logic [NRD-1:0][XLEN-1:0]  rd_data_s;
    logic [NRD-1:0]            rd_busy_s;

    regfile_wr_arb #(
        .NREG (NREG),
        .NWR  (NWR),
        .AW   (AW),
        .SW   (SW)
    ) u_wr_arb (
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .reg_we  (reg_we_s),
        .reg_sel (reg_sel_s)
    );

    // Next busy vector: clears first, then issue, so a same-cycle issue wins.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int p = 0; p < NWR; p++) begin
            busy_nxt_s[bus.wr_addr[p]] = busy_nxt_s[bus.wr_addr[p]] & ~(bus.wr_en[p] & bus.wr_clr[p]);
        end
        busy_nxt_s[bus.iss_addr] = busy_nxt_s[bus.iss_addr] | bus.iss_en;
        busy_nxt_s[0] = 1'b0;
    end

    // Popcount of the next busy vector, registered alongside it.
    always_comb begin
        cnt_nxt_s = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt_s = cnt_nxt_s + {{AW{1'b0}}, busy_nxt_s[r]};
        end
    end

    // Register array, busy vector and busy count.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            rf_r       <= '0;
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (reg_we_s[r]) begin
                    rf_r[r] <= bus.wr_data[reg_sel_s[r]];
                end else begin
                    rf_r[r] <= rf_r[r];
                end
            end
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= cnt_nxt_s;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] fwd_clr_s;

    // Forward the winning write port; its clear hides busy unless a new producer issues.
    always_comb begin
        rd_data_s = '0;
        rd_busy_s = '0;
        fwd_clr_s = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data_s[i] = reg_we_s[bus.rd_addr[i]] ? bus.wr_data[reg_sel_s[bus.rd_addr[i]]]
                                                    : rf_r[bus.rd_addr[i]];
            fwd_clr_s[i] = reg_we_s[bus.rd_addr[i]] & bus.wr_clr[reg_sel_s[bus.rd_addr[i]]]
                         & ~(bus.iss_en & (bus.iss_addr == bus.rd_addr[i]));
            rd_busy_s[i] = busy_r[bus.rd_addr[i]] & ~fwd_clr_s[i];
        end
    end
`else
    // Reads see pre-edge state; x0 is held at zero and never busy.
    always_comb begin
        rd_data_s = '0;
        rd_busy_s = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_data_s[i] = rf_r[bus.rd_addr[i]];
            rd_busy_s[i] = busy_r[bus.rd_addr[i]];
        end
    end
`endif

    assign bus.rd_data  = rd_data_s;
    assign bus.rd_busy  = rd_busy_s;
    assign bus.busy_cnt = busy_cnt_r;

endmodule
